// File: rtl/id_ex_stage_pkg.sv
// Shared widths, x0 constant, ID/EX stage-register layout and the write-back match helper.
package id_ex_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  alu_src;
    } stage_t;

    // A write-back to x0 never counts as a match.
    function automatic logic wb_hits(input logic                  we,
                                     input logic [REG_ADDR_W-1:0] wb_rd,
                                     input logic [REG_ADDR_W-1:0] rs);
        return we && (wb_rd != X0) && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side, control, forwarding and EX-side signals around the ID/EX register.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [XLEN-1:0]       id_imm;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_alu_src;

    logic                  flush;
    logic                  mem_stall;

    logic                  fwd_a;
    logic                  fwd_b;
    logic [XLEN-1:0]       exmem_result;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_write_enable;
    logic [XLEN-1:0]       wb_data;

    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [XLEN-1:0]       ex_op_a;
    logic [XLEN-1:0]       ex_op_b;
    logic [XLEN-1:0]       ex_store_data;
    logic                  load_use_stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_reg_write, id_mem_read, id_alu_src, flush, mem_stall,
               fwd_a, fwd_b, exmem_result, wb_rd, wb_write_enable, wb_data,
        input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
               ex_op_a, ex_op_b, ex_store_data, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_reg_write, id_mem_read, id_alu_src, flush, mem_stall,
               fwd_a, fwd_b, exmem_result, wb_rd, wb_write_enable, wb_data,
        output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
               ex_op_a, ex_op_b, ex_store_data, load_use_stall
    );

endinterface

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// Per-operand forwarding select: EX/MEM result, then write-back bypass, then stored value.
module operand_fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic                  fwd_sel_i,
    input  logic [XLEN-1:0]       exmem_result_i,
    input  logic                  wb_write_enable_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]       wb_data_i,
    input  logic [REG_ADDR_W-1:0] ex_rs_i,
    input  logic [XLEN-1:0]       stored_data_i,
    output logic [XLEN-1:0]       fwd_data_o
);

    always_comb begin
        fwd_data_o = stored_data_i;
        if (fwd_sel_i) begin
            fwd_data_o = exmem_result_i;
        end else if (wb_hits(wb_write_enable_i, wb_rd_i, ex_rs_i)) begin
            fwd_data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, write-back capture and operand forwarding.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    stage_t          stage_q;
    stage_t          stage_d;
    logic            load_use;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign load_use = stage_q.valid && stage_q.mem_read && (stage_q.rd != X0) && bus.id_valid &&
                      ((stage_q.rd == bus.id_rs1) || (stage_q.rd == bus.id_rs2));

    // Priority: flush, hold, load-use bubble, load.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = '0;
        end else if (bus.mem_stall) begin
            if (wb_hits(bus.wb_write_enable, bus.wb_rd, stage_q.rs1)) begin
                stage_d.rs1_data = bus.wb_data;
            end
            if (wb_hits(bus.wb_write_enable, bus.wb_rd, stage_q.rs2)) begin
                stage_d.rs2_data = bus.wb_data;
            end
        end else if (load_use) begin
            stage_d = '0;
        end else begin
            stage_d.valid     = bus.id_valid;
            stage_d.rs1       = bus.id_rs1;
            stage_d.rs2       = bus.id_rs2;
            stage_d.rd        = bus.id_rd;
            stage_d.imm       = bus.id_imm;
            stage_d.reg_write = bus.id_reg_write;
            stage_d.mem_read  = bus.id_mem_read;
            stage_d.alu_src   = bus.id_alu_src;
            stage_d.rs1_data  = wb_hits(bus.wb_write_enable, bus.wb_rd, bus.id_rs1) ?
                                bus.wb_data : bus.id_rs1_data;
            stage_d.rs2_data  = wb_hits(bus.wb_write_enable, bus.wb_rd, bus.id_rs2) ?
                                bus.wb_data : bus.id_rs2_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    operand_fwd_mux u_fwd_rs1 (
        .fwd_sel_i         (bus.fwd_a),
        .exmem_result_i    (bus.exmem_result),
        .wb_write_enable_i (bus.wb_write_enable),
        .wb_rd_i           (bus.wb_rd),
        .wb_data_i         (bus.wb_data),
        .ex_rs_i           (stage_q.rs1),
        .stored_data_i     (stage_q.rs1_data),
        .fwd_data_o        (fwd_rs1)
    );

    operand_fwd_mux u_fwd_rs2 (
        .fwd_sel_i         (bus.fwd_b),
        .exmem_result_i    (bus.exmem_result),
        .wb_write_enable_i (bus.wb_write_enable),
        .wb_rd_i           (bus.wb_rd),
        .wb_data_i         (bus.wb_data),
        .ex_rs_i           (stage_q.rs2),
        .stored_data_i     (stage_q.rs2_data),
        .fwd_data_o        (fwd_rs2)
    );

    assign bus.ex_valid       = stage_q.valid;
    assign bus.ex_rs1         = stage_q.rs1;
    assign bus.ex_rs2         = stage_q.rs2;
    assign bus.ex_rd          = stage_q.rd;
    assign bus.ex_reg_write   = stage_q.reg_write;
    assign bus.ex_mem_read    = stage_q.mem_read;
    assign bus.ex_op_a        = fwd_rs1;
    assign bus.ex_op_b        = stage_q.alu_src ? stage_q.imm : fwd_rs2;
    assign bus.ex_store_data  = fwd_rs2;
    assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each edge's stage contents.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        as;
    } mdl_t;

    typedef logic [113:0] vec_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    mdl_t m;
    mdl_t sbq[$];

    id_ex_stage_if bus();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t obs_vec();
        return {bus.ex_valid, bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_reg_write,
                bus.ex_mem_read, bus.ex_op_a, bus.ex_op_b, bus.ex_store_data};
    endfunction

    // Outputs expected with all forwarding inputs idle.
    function automatic vec_t exp_vec(input mdl_t e);
        return {e.valid, e.rs1, e.rs2, e.rd, e.rw, e.mr, e.d1, (e.as ? e.imm : e.d2), e.d2};
    endfunction

    function automatic logic hit(input logic [4:0] rs);
        return bus.wb_write_enable && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs);
    endfunction

    function automatic mdl_t model_next(input mdl_t c);
        mdl_t n;
        logic lus;
        n   = c;
        lus = c.valid && c.mr && (c.rd != 5'd0) && bus.id_valid &&
              ((c.rd == bus.id_rs1) || (c.rd == bus.id_rs2));
        if (bus.flush) begin
            n = '0;
        end else if (bus.mem_stall) begin
            if (hit(c.rs1)) n.d1 = bus.wb_data;
            if (hit(c.rs2)) n.d2 = bus.wb_data;
        end else if (lus) begin
            n = '0;
        end else begin
            n.valid = bus.id_valid;
            n.rs1   = bus.id_rs1;
            n.rs2   = bus.id_rs2;
            n.rd    = bus.id_rd;
            n.imm   = bus.id_imm;
            n.rw    = bus.id_reg_write;
            n.mr    = bus.id_mem_read;
            n.as    = bus.id_alu_src;
            n.d1    = hit(bus.id_rs1) ? bus.wb_data : bus.id_rs1_data;
            n.d2    = hit(bus.id_rs2) ? bus.wb_data : bus.id_rs2_data;
        end
        return n;
    endfunction

    task automatic idle_fwd();
        bus.fwd_a           = 1'b0;
        bus.fwd_b           = 1'b0;
        bus.exmem_result    = '0;
        bus.wb_rd           = '0;
        bus.wb_write_enable = 1'b0;
        bus.wb_data         = '0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic rw, input logic mr,
                            input logic as);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_rs1_data  = d1;
        bus.id_rs2_data  = d2;
        bus.id_imm       = imm;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_alu_src   = as;
    endtask

    // Predict the coming edge, take it, then idle the forwarding inputs for sampling.
    task automatic cycle();
        mdl_t nx;
        nx = model_next(m);
        sbq.push_back(nx);
        m = nx;
        @(posedge clk);
        #1;
        idle_fwd();
        #1;
    endtask

    task automatic test_reset();
        mdl_t e;
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.mem_stall = 1'b0;
        idle_fwd();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1, 1'b0);
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs_vec() !== exp_vec(m)) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", obs_vec(), exp_vec(m));
        end
        total++;
        if (bus.load_use_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_lus got=%b want=0", bus.load_use_stall);
        end
        @(negedge clk);
        rst = 1'b1;
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) begin
            bad++;
            $display("FAIL first_load got=%h want=%h", obs_vec(), exp_vec(e));
        end
    endtask

    task automatic test_load_use();
        mdl_t e;
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, 32'hA1, 32'hA2, 32'h0, 1'b1, 1'b1, 1'b1);
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) begin
            bad++;
            $display("FAIL lu_load got=%h want=%h", obs_vec(), exp_vec(e));
        end
        drive_id(1'b1, 5'd5, 5'd9, 5'd10, 32'hB1, 32'hB2, 32'h4, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if (bus.load_use_stall !== 1'b1) begin
            bad++;
            $display("FAIL lu_detect got=%b want=1", bus.load_use_stall);
        end
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e) || bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0) begin
            bad++;
            $display("FAIL lu_bubble got=%h want=%h", obs_vec(), exp_vec(e));
        end
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) begin
            bad++;
            $display("FAIL lu_reload got=%h want=%h", obs_vec(), exp_vec(e));
        end
    endtask

    task automatic test_forwarding();
        mdl_t e;
        drive_id(1'b1, 5'd3, 5'd4, 5'd12, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) begin
            bad++;
            $display("FAIL fwd_load got=%h want=%h", obs_vec(), exp_vec(e));
        end
        bus.fwd_a = 1'b1;
        bus.exmem_result = 32'hDEADBEEF;
        bus.wb_write_enable = 1'b1;
        bus.wb_rd = 5'd3;
        bus.wb_data = 32'h1234;
        #1;
        total++;
        if (bus.ex_op_a !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL fwd_a_exmem got=%h want=deadbeef", bus.ex_op_a);
        end
        bus.fwd_a = 1'b0;
        #1;
        total++;
        if (bus.ex_op_a !== 32'h1234) begin
            bad++;
            $display("FAIL fwd_a_wb got=%h want=00001234", bus.ex_op_a);
        end
        bus.fwd_b = 1'b1;
        bus.exmem_result = 32'hCAFEF00D;
        #1;
        total++;
        if (bus.ex_op_b !== 32'hCAFEF00D || bus.ex_store_data !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL fwd_b_exmem got=%h/%h want=cafef00d", bus.ex_op_b, bus.ex_store_data);
        end
        idle_fwd();
        drive_id(1'b1, 5'd6, 5'd7, 5'd13, 32'h5, 32'h6, 32'h77, 1'b1, 1'b0, 1'b1);
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) begin
            bad++;
            $display("FAIL imm_load got=%h want=%h", obs_vec(), exp_vec(e));
        end
        bus.wb_write_enable = 1'b1;
        bus.wb_rd = 5'd7;
        bus.wb_data = 32'h99;
        #1;
        total++;
        if (bus.ex_op_b !== 32'h77 || bus.ex_store_data !== 32'h99) begin
            bad++;
            $display("FAIL imm_select got=%h/%h want=00000077/00000099", bus.ex_op_b, bus.ex_store_data);
        end
        idle_fwd();
    endtask

    task automatic test_hold_capture();
        mdl_t e;
        drive_id(1'b1, 5'd8, 5'd7, 5'd9, 32'h10, 32'h11, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) begin
            bad++;
            $display("FAIL hold_load got=%h want=%h", obs_vec(), exp_vec(e));
        end
        drive_id(1'b1, 5'd1, 5'd1, 5'd2, 32'hEE, 32'hEE, 32'hEE, 1'b1, 1'b0, 1'b0);
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                bus.wb_write_enable = 1'b1;
                bus.wb_rd = 5'd7;
                bus.wb_data = 32'h55;
            end
            cycle();
            e = sbq.pop_front();
            total++;
            if (obs_vec() !== exp_vec(e)) begin
                bad++;
                $display("FAIL hold_cycle%0d got=%h want=%h", i, obs_vec(), exp_vec(e));
            end
        end
        bus.mem_stall = 1'b0;
        #1;
        total++;
        if (bus.ex_store_data !== 32'h55 || bus.ex_op_a !== 32'h10) begin
            bad++;
            $display("FAIL hold_release got=%h/%h want=00000055/00000010", bus.ex_store_data, bus.ex_op_a);
        end
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) begin
            bad++;
            $display("FAIL hold_next got=%h want=%h", obs_vec(), exp_vec(e));
        end
    endtask

    task automatic test_x0();
        mdl_t e;
        drive_id(1'b1, 5'd0, 5'd0, 5'd4, 32'hAB, 32'hCD, 32'h0, 1'b1, 1'b0, 1'b0);
        bus.wb_write_enable = 1'b1;
        bus.wb_rd = 5'd0;
        bus.wb_data = 32'hFF;
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e) || bus.ex_op_a !== 32'hAB) begin
            bad++;
            $display("FAIL x0_capture got=%h want=%h", obs_vec(), exp_vec(e));
        end
        bus.wb_write_enable = 1'b1;
        bus.wb_rd = 5'd0;
        bus.wb_data = 32'hFF;
        #1;
        total++;
        if (bus.ex_op_a !== 32'hAB || bus.ex_store_data !== 32'hCD) begin
            bad++;
            $display("FAIL x0_forward got=%h/%h want=000000ab/000000cd", bus.ex_op_a, bus.ex_store_data);
        end
        idle_fwd();
    endtask

    task automatic test_flush();
        mdl_t e;
        drive_id(1'b1, 5'd2, 5'd3, 5'd4, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0, 1'b0);
        bus.flush = 1'b1;
        bus.mem_stall = 1'b1;
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e) || bus.ex_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall got=%h want=%h", obs_vec(), exp_vec(e));
        end
        bus.flush = 1'b0;
        bus.mem_stall = 1'b0;
        drive_id(1'b1, 5'd1, 5'd2, 5'd6, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1, 1'b1);
        cycle();
        void'(sbq.pop_front());
        drive_id(1'b1, 5'd6, 5'd0, 5'd7, 32'h61, 32'h62, 32'h0, 1'b1, 1'b0, 1'b0);
        bus.flush = 1'b1;
        #1;
        total++;
        if (bus.load_use_stall !== 1'b1) begin
            bad++;
            $display("FAIL flush_lus_comb got=%b want=1", bus.load_use_stall);
        end
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) begin
            bad++;
            $display("FAIL flush_lus_bubble got=%h want=%h", obs_vec(), exp_vec(e));
        end
        bus.flush = 1'b0;
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e) || bus.ex_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_lus_single got=%h want=%h", obs_vec(), exp_vec(e));
        end
    endtask

    task automatic test_lus_stall();
        mdl_t e;
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1, 1'b1);
        cycle();
        void'(sbq.pop_front());
        drive_id(1'b1, 5'd3, 5'd8, 5'd9, 32'h81, 32'h82, 32'h0, 1'b1, 1'b0, 1'b0);
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) bus.mem_stall = 1'b0;
            cycle();
            e = sbq.pop_front();
            total++;
            if (obs_vec() !== exp_vec(e)) begin
                bad++;
                $display("FAIL lus_stall_step%0d got=%h want=%h", i, obs_vec(), exp_vec(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        mdl_t e;
        for (int i = 0; i < 60; i++) begin
            drive_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                     $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            bus.flush = 1'($urandom_range(0, 7) == 0);
            bus.mem_stall = 1'($urandom_range(0, 4) == 0);
            bus.wb_write_enable = 1'($urandom);
            bus.wb_rd = 5'($urandom_range(0, 7));
            bus.wb_data = $urandom;
            cycle();
            e = sbq.pop_front();
            total++;
            if (obs_vec() !== exp_vec(e)) begin
                bad++;
                $display("FAIL b2b_%0d got=%h want=%h", i, obs_vec(), exp_vec(e));
            end
        end
        bus.flush = 1'b0;
        bus.mem_stall = 1'b0;
    endtask

    task automatic test_async_reset();
        mdl_t e;
        drive_id(1'b1, 5'd1, 5'd2, 5'd11, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1, 1'b1);
        cycle();
        void'(sbq.pop_front());
        drive_id(1'b1, 5'd11, 5'd0, 5'd12, 32'hC1, 32'hC2, 32'h0, 1'b1, 1'b0, 1'b0);
        bus.mem_stall = 1'b1;
        #1;
        rst = 1'b0;
        m = '0;
        #1;
        total++;
        if (obs_vec() !== exp_vec(m) || bus.load_use_stall !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got=%h lus=%b want=%h lus=0", obs_vec(), bus.load_use_stall, exp_vec(m));
        end
        bus.mem_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        e = sbq.pop_front();
        total++;
        if (obs_vec() !== exp_vec(e)) begin
            bad++;
            $display("FAIL post_reset_load got=%h want=%h", obs_vec(), exp_vec(e));
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_hold_capture();
        test_x0();
        test_flush();
        test_lus_stall();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
